// File: rtl/rr_mux_arbiter_4x1_pkg.sv
// rr_mux_arbiter_4x1_pkg: shared state encoding, sizes and round-robin search helper.
package rr_mux_arbiter_4x1_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    // Returns {found, index} of the first set bit in cand, scanning ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [SEL_W:0] pick(input logic [SEL_W-1:0] ptr, input logic [NUM_REQ-1:0] cand);
        logic [SEL_W:0] r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (cand[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_4x1_mux.sv
// mux_4x1: plain 4:1 bit multiplexer.
module mux_4x1 (
    input  logic [3:0] I,
    input  logic [1:0] S,
    output logic       Y
);
    assign Y = I[S];
endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// rr_mux_arbiter_4x1: round-robin arbiter with hold limit sharing one 4:1 bit-mux channel.
module rr_mux_arbiter_4x1
    import rr_mux_arbiter_4x1_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]     sel,
    output logic                 valid,
    output logic                 data_out
);
    localparam logic [3:0] LIM = 4'(HOLD_MAX - 1);
    state_t          state;
    logic [3:0]      hold_cnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W:0]  win;
    logic            owner_req, take, mux_y;
    assign owner_req = req[sel];
    // While busy, ptr equals the owner, so masking it leaves only the contenders.
    assign win  = pick(ptr, state == BUSY ? req & ~(4'b0001 << sel) : req);
    assign take = win[SEL_W] && (state == IDLE || !owner_req || hold_cnt == LIM);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'd3;
        end else if (take) begin
            state    <= BUSY;
            gnt      <= 4'b0001 << win[SEL_W-1:0];
            sel      <= win[SEL_W-1:0];
            valid    <= 1'b1;
            hold_cnt <= '0;
            ptr      <= win[SEL_W-1:0];
        end else if (state == BUSY && !owner_req) begin
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
        end else if (state == BUSY && hold_cnt != LIM) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end
    mux_4x1 u_mux (.I(data_in), .S(sel), .Y(mux_y));
    assign data_out = mux_y & valid;
endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// tb_rr_mux_arbiter_4x1: scoreboard bench with a behavioural round-robin model and directed scenarios.
module tb_rr_mux_arbiter_4x1;
    localparam int HM = 4;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       dout;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] data_in = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid, data_out;
    int         errs = 0, checks = 0;
    int         m_sel = 0, m_ptr = 3, m_cnt = 0;
    bit         m_valid = 0;
    exp_t       q[$];

    rr_mux_arbiter_4x1 #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .gnt(gnt), .sel(sel), .valid(valid), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_ptr = 3; m_cnt = 0; m_valid = 0;
    endtask

    task automatic model_grant(input logic [3:0] c);
        for (int k = 1; k <= 4; k++) begin
            if (c[(m_ptr + k) % 4]) begin
                m_sel = (m_ptr + k) % 4;
                break;
            end
        end
        m_ptr = m_sel; m_valid = 1; m_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        others = r & ~(4'b0001 << m_sel);
        if (!m_valid) begin
            if (r != 0) model_grant(r);
        end else if (!r[m_sel]) begin
            if (others != 0) model_grant(others);
            else m_valid = 0;
        end else if (others != 0 && m_cnt == HM - 1) begin
            model_grant(others);
        end else if (m_cnt < HM - 1) begin
            m_cnt++;
        end
    endtask

    // Called shortly after a falling edge; returns at the following falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        req = r;
        data_in = d;
        model_step(r);
        e.valid = m_valid;
        e.sel   = 2'(m_sel);
        e.gnt   = m_valid ? 4'(1 << m_sel) : 4'b0000;
        e.dout  = m_valid & d[m_sel];
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("sel", 32'(sel), 32'(e.sel));
            check("valid", 32'(valid), 32'(e.valid));
            check("data_out", 32'(data_out), 32'(e.dout));
        end
        @(negedge clk);
    endtask

    initial begin
        req = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        rst_n = 1'b1;
        model_reset();
        // Full contention: owners 0,1,2,3,0 each for HM cycles.
        for (int k = 0; k < 5 * HM; k++) begin
            step(4'b1111, 4'b1010);
            check("fair_owner", 32'(sel), 32'((k / HM) % 4));
        end
        // Single requester holds indefinitely, then goes idle keeping sel.
        for (int k = 0; k < 20; k++) begin
            step(4'b0100, 4'b0100);
            check("single_hold", 32'(gnt), 32'h4);
        end
        step(4'b0000, 4'b0100);
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_sel", 32'(sel), 32'h2);
        // Last owner 2: order 3,0,1,2 so requester 0 wins.
        step(4'b0011, 4'b0001);
        check("skip_owner", 32'(sel), 32'h0);
        for (int k = 0; k < HM; k++) step(4'b0011, 4'b0010);
        check("rot_owner", 32'(sel), 32'h1);
        step(4'b0001, 4'b0001);
        check("handoff_gnt", 32'(gnt), 32'h1);
        check("handoff_valid", 32'(valid), 32'h1);
        // Owner 3 reaches hold_cnt 2, then async reset between edges.
        for (int k = 0; k < 3; k++) step(4'b1000, 4'b1000);
        check("pre_rst_cnt", 32'(dut.hold_cnt), 32'h2);
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_sel", 32'(sel), 32'h0);
        check("async_valid", 32'(valid), 32'h0);
        check("async_dout", 32'(data_out), 32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(4'b1000, 4'b1000);
        check("post_rst_gnt", 32'(gnt), 32'h8);
        check("post_rst_cnt", 32'(dut.hold_cnt), 32'h0);
        for (int k = 0; k < 6; k++) step(4'b1001, 4'b1001);
        for (int k = 0; k < 300; k++) step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter_4x1.md
Name: rr_mux_arbiter_4x1

Overview:
- Round-robin arbiter that shares one 4:1 bit-mux channel between four requesters.
- Registers a one-hot grant and the matching 2-bit select.
- Routes the granted requester's data bit to a single output through an instantiated mux_4x1.
- Sits between four serial-bit producers and one shared downstream consumer.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one requester keeps the grant while another requester is waiting. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- data_in  input  4  data bit per requester; feeds mux input I.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered select driving mux S; index of the current/last owner.
- valid  output  1  registered; high when a grant is active.
- data_out  output  1  data_in[sel] when valid, else 0 (combinational from registered sel).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0000, sel=00, valid=0, state=IDLE, hold_cnt=0.
  - Last-owner pointer resets to 3, so the first priority goes to requester 0.
- States:
  - IDLE: no grant active.
  - BUSY: one owner holds the grant.
- Latency: req sampled at edge n produces gnt/sel/valid after edge n; data_out follows in the same cycle. Fixed 1-cycle request-to-grant.
- Search order: ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last owner. First asserted req in that order wins.
- IDLE:
  - req=0000: stay IDLE.
  - Otherwise: grant the search winner, go to BUSY, hold_cnt=0.
- BUSY, owner still requesting:
  - No other req bit set: keep the grant indefinitely. hold_cnt saturates at HOLD_MAX-1.
  - Others requesting and hold_cnt < HOLD_MAX-1: keep the grant, hold_cnt+1.
  - Others requesting and hold_cnt = HOLD_MAX-1: rotate to the search winner (excludes owner), hold_cnt=0.
- BUSY, owner drops req:
  - Any other req set: grant the search winner in the same edge (no idle bubble), hold_cnt=0.
  - No req set: go to IDLE, gnt=0000, valid=0. sel and ptr keep the last owner.
- Simultaneous requests are resolved purely by pointer order. The pointer updates on every new grant.
- HOLD_MAX=1: the grant rotates every cycle whenever there is contention.
- Reset asserted mid-grant: outputs clear immediately (async). The pointer returns to 3.
- data_out: mux_4x1 output ANDed with valid. There is no extra register stage.
- gnt is always one-hot or zero and always equals decode(sel) when valid=1.
- hold_cnt width: 4 bits, covering HOLD_MAX up to 15.

Decomposition:
- Shared package/header holds:
  - State encoding constants: IDLE=1'b0, BUSY=1'b1.
  - NUM_REQ=4.
  - Select width 2.
- Sub-module: the existing mux_4x1 (I, S, Y), instantiated once with I=data_in, S=sel.
- The arbiter FSM, pointer and hold counter live in this module. There is no further split.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> gnt=0000, sel=00, valid=0, data_out=0. Release -> after the first edge, gnt=0001, sel=00.
- Single requester: req=0100, data_in=0100 -> next edge gives gnt=0100, sel=10, valid=1, data_out=1. Grant is held for 20 cycles with no rotation. Dropping req gives IDLE with gnt=0000.
- Contention fairness, HOLD_MAX=4: req=1111 from reset -> owners 0,1,2,3,0 in that order, each for exactly 4 cycles.
- Hand-off without bubble: owner 1 with req=0011; drop to req=0001 -> next edge gnt=0001, valid stays 1.
- Pointer skip: last owner 2, then req=0011 -> grant goes to 0, not 1 (order 3,0,1,2).
- Async reset mid-grant: owner 3 at hold_cnt=2, pulse rst_n low between edges -> outputs clear immediately. After release with req=1000 -> gnt=1000 after one edge, hold_cnt restarts at 0.
